// File: rtl/bcd_serial_alu_ctrl.sv
// Multi-digit BCD add/subtract controller: one shared digit adder walked LSD-first,
// sign-magnitude result, plus a free-running common-anode seven-segment scanner.
module bcd_serial_alu_ctrl #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  c_sign,
  output logic                  err,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an,
  output logic [1:0]            dbg_state
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;
  state_t state, state_next;

  logic [W-1:0]  x_reg, y_reg, work, work_next;
  logic          mode_reg, neg, cb, cb_next, last_dig, bad_digit;
  logic [IW-1:0] idx;
  logic [3:0]    x_dig, y_dig, dig;
  logic [4:0]    sum5, dif5;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign last_dig  = (idx == IW'(DIGITS - 1));
  assign x_dig     = x_reg[{idx, 2'b00} +: 4];
  assign y_dig     = y_reg[{idx, 2'b00} +: 4];

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (x_reg[4*i +: 4] > 4'd9 || y_reg[4*i +: 4] > 4'd9) bad_digit = 1'b1;
  end

  // One digit step; cb is carry for add, borrow for subtract.
  always_comb begin
    sum5 = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, cb};
    dif5 = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, cb};
    if (!mode_reg) begin
      cb_next = (sum5 > 5'd9);
      dig     = cb_next ? 4'(sum5 + 5'd6) : sum5[3:0];
    end else begin
      cb_next = dif5[4];
      dig     = cb_next ? (dif5[3:0] + 4'd10) : dif5[3:0];
    end
    work_next = work;
    work_next[{idx, 2'b00} +: 4] = dig;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = bad_digit ? DONE : RUN;
      RUN:     if (last_dig) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_reg    <= '0;
      y_reg    <= '0;
      mode_reg <= 1'b0;
      neg      <= 1'b0;
      cb       <= 1'b0;
      idx      <= '0;
      work     <= '0;
      result   <= '0;
      c_sign   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          x_reg    <= a_bcd;
          y_reg    <= b_bcd;
          mode_reg <= mode;
        end
        CHECK: begin
          idx  <= '0;
          cb   <= 1'b0;
          work <= '0;
          neg  <= 1'b0;
          if (bad_digit) begin
            result <= '1;
            c_sign <= 1'b0;
            err    <= 1'b1;
          end else if (mode_reg && (x_reg < y_reg)) begin
            // Subtract larger minus smaller so the last digit never borrows.
            x_reg <= y_reg;
            y_reg <= x_reg;
            neg   <= 1'b1;
          end
        end
        RUN: begin
          work <= work_next;
          cb   <= cb_next;
          idx  <= idx + 1'b1;
          if (last_dig) begin
            result <= work_next;
            c_sign <= mode_reg ? neg : cb_next;
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic [3:0]    scan_dig;
  logic [6:0]    seg_dec;

  assign scan_dig = result[{scan_idx, 2'b00} +: 4];

  always_comb begin
    case (scan_dig)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // an/seg_out are registered together so the enable and pattern always agree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an       <= '1;
      seg_out  <= 7'b1111111;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an      <= ~(DIGITS'(1) << scan_idx);
      seg_out <= seg_dec;
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu_ctrl.sv
// Directed bench for bcd_serial_alu_ctrl: hand-computed BCD results, latency,
// handshake, error path, reset abort and display scan order.
module tb_bcd_serial_alu_ctrl;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;
  localparam int W        = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [W-1:0]      a_bcd = '0;
  logic [W-1:0]      b_bcd = '0;
  logic              busy, done, c_sign, err;
  logic [W-1:0]      result;
  logic [6:0]        seg_out;
  logic [DIGITS-1:0] an;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  bcd_serial_alu_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .busy(busy), .done(done),
    .result(result), .c_sign(c_sign), .err(err),
    .seg_out(seg_out), .an(an), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one operation; noise scrambles inputs/start while busy and holds
  // start high through the DONE cycle to show it is not accepted.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic [W-1:0] exp_res, input logic exp_c,
                        input logic exp_err, input int exp_lat, input bit noise);
    int n;
    bit busy_ok;
    @(negedge clk);
    a_bcd = a; b_bcd = b; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a_bcd = W'($urandom);
        b_bcd = W'($urandom);
        mode  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_before"}, busy_ok, 1);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_c_sign"}, c_sign, exp_c);
    check({tag, "_err"}, err, exp_err);
    start = noise;
    @(negedge clk);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    start = 1'b0;
    if (noise) begin
      @(negedge clk);
      check({tag, "_no_restart"}, busy, 0);
    end
  endtask

  task automatic check_display(input string tag, input logic [W-1:0] val);
    logic [DIGITS-1:0] prev, exp_an;
    logic [3:0] d;
    int n;
    prev = an;
    n = 0;
    @(negedge clk);
    while (!(an == 4'b1110 && prev != 4'b1110) && n < 20) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    check({tag, "_sync"}, (n < 20), 1);
    for (int k = 0; k < 2 * DIGITS; k++) begin
      d = val[4*(k/2) +: 4];
      exp_an = ~(DIGITS'(1) << (k / 2));
      check($sformatf("%s_an%0d", tag, k), an, exp_an);
      check($sformatf("%s_seg%0d", tag, k), seg_out, seg_tab[d]);
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen_done;
    for (int i = 0; i < 16; i++) seg_tab[i] = 7'b1111111;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_c_sign", c_sign, 0);
    check("rst_err", err, 0);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg_out, 7'h7F);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    run_op("add_0457_0389", 16'h0457, 16'h0389, 1'b0, 16'h0846, 1'b0, 1'b0, 6, 1'b0);
    check_display("disp_0846", 16'h0846);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 6, 1'b0);
    run_op("sub_1000_0001", 16'h1000, 16'h0001, 1'b1, 16'h0999, 1'b0, 1'b0, 6, 1'b0);
    run_op("sub_0120_0457", 16'h0120, 16'h0457, 1'b1, 16'h0337, 1'b1, 1'b0, 6, 1'b0);
    run_op("sub_0500_0500", 16'h0500, 16'h0500, 1'b1, 16'h0000, 1'b0, 1'b0, 6, 1'b0);
    run_op("add_5678_4321", 16'h5678, 16'h4321, 1'b0, 16'h9999, 1'b0, 1'b0, 6, 1'b0);
    run_op("err_12A4", 16'h12A4, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b1, 2, 1'b0);
    for (int k = 0; k < 2 * DIGITS; k++) begin
      check($sformatf("blank_seg%0d", k), seg_out, 7'h7F);
      @(negedge clk);
    end
    run_op("add_0001_0002", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 6, 1'b0);
    run_op("noisy_add", 16'h0457, 16'h0389, 1'b0, 16'h0846, 1'b0, 1'b0, 6, 1'b1);

    // Abort an operation mid-RUN with reset.
    @(negedge clk);
    a_bcd = 16'h1234; b_bcd = 16'h4321; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_in_run", dbg_state, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_c_sign", c_sign, 0);
    check("abort_err", err, 0);
    check("abort_an", an, 4'hF);
    check("abort_seg", seg_out, 7'h7F);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
